lifo_drain: RTL and testbench

- Downstream consumer for a single-clock FWFT LIFO (stack) buffer.
- On a start command it pops a burst of up to len words from the stack's read port.
- It emits the words on a valid/ready stream, top-of-stack first, and flags the final word with m_last.
- It is the standard bridge from stack storage to packetised stream sinks.

---
 rtl/lifo_drain.sv | 75 +++++++
 tb/tb_lifo_drain.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_drain.sv
// lifo_drain: pops a burst of up to len words from an FWFT stack and streams them out, top first.
module lifo_drain #(
    parameter int DEPTH = 8,
    parameter int DATA_W = 32,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              lifo_r_req,
    input  logic [DATA_W-1:0] lifo_r_data,
    input  logic              lifo_empty,
    input  logic [LEN_W-1:0]  lifo_cnt,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, POP, FLUSH} state_t;
    state_t state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] eff;
    logic pop;
    logic hs;
    assign eff = (len < lifo_cnt) ? len : lifo_cnt;
    assign hs = m_valid && m_ready;
    // a pop refills the single output stage only when it is empty or draining this cycle
    assign pop = (state == POP) && (remaining != '0) && !lifo_empty && (!m_valid || m_ready);
    assign lifo_r_req = pop;
    assign busy = (state != IDLE);
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            remaining <= '0;
            m_data <= '0;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            if (pop) begin
                m_data <= lifo_r_data;
                m_valid <= 1'b1;
                m_last <= (remaining == LEN_W'(1));
                remaining <= remaining - LEN_W'(1);
            end else if (hs) begin
                m_valid <= 1'b0;
                m_last <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && eff == '0) err <= 1'b1;
                    else if (start) begin
                        remaining <= eff;
                        state <= POP;
                    end
                end
                POP: if (pop && remaining == LEN_W'(1)) state <= FLUSH;
                FLUSH: begin
                    if (hs) begin
                        done <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lifo_drain.sv
// tb_lifo_drain: drives lifo_drain from a behavioural stack and scores the stream against expected top-first order.
module tb_lifo_drain;
    localparam int DEPTH = 8;
    localparam int DW = 32;
    localparam int LW = $clog2(DEPTH + 1);
    logic clk = 0, nrst = 0, start = 0, m_ready = 1;
    logic lifo_r_req, lifo_empty, m_valid, m_last, busy, done, err;
    logic [LW-1:0] len = '0, lifo_cnt;
    logic [DW-1:0] lifo_r_data, m_data;
    logic push = 0, clr = 0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] mem [DEPTH];
    int sp = 0;
    int checks = 0, errors = 0, pops = 0, dones = 0, errs = 0;
    logic [DW-1:0] exp_q [$];
    logic stall = 0, pl = 0;
    logic [DW-1:0] pd = '0;

    always #5 clk = ~clk;

    lifo_drain #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk(clk), .nrst(nrst), .start(start), .len(len),
        .lifo_r_req(lifo_r_req), .lifo_r_data(lifo_r_data), .lifo_empty(lifo_empty), .lifo_cnt(lifo_cnt),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .err(err)
    );

    assign lifo_empty = (sp == 0);
    assign lifo_cnt = LW'(sp);
    assign lifo_r_data = (sp > 0) ? mem[sp-1] : '0;

    // stack model: a simultaneous push and pop replaces the top word
    always @(posedge clk) begin
        if (clr) sp <= 0;
        else if (lifo_r_req && push) mem[sp-1] <= push_data;
        else if (lifo_r_req) sp <= sp - 1;
        else if (push && sp < DEPTH) begin
            mem[sp] <= push_data;
            sp <= sp + 1;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!nrst) stall <= 1'b0;
        else begin
            if (stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, pd);
                chk("hold_last", m_last, pl);
            end
            if (lifo_empty) chk("req_when_empty", lifo_r_req, 0);
            if (m_valid && !m_ready) chk("pop_while_stalled", lifo_r_req, 0);
            if (done || err) chk("done_and_err", done && err, 0);
            if (lifo_r_req) pops <= pops + 1;
            if (done) dones <= dones + 1;
            if (err) errs <= errs + 1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 1, 0);
                else begin
                    chk("m_data", m_data, exp_q[0]);
                    chk("m_last", m_last, exp_q.size() == 1);
                    void'(exp_q.pop_front());
                end
            end
            stall <= m_valid && !m_ready;
            pd <= m_data;
            pl <= m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        push = 1;
        push_data = d;
        step();
        push = 0;
    endtask

    task automatic clear();
        clr = 1;
        step();
        clr = 0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready pattern 0,0,1,0,1,1 then high
    task automatic burst(input int l, input int mode, input bit restart);
        int eff, sp0, p0, d0, e0, n;
        logic [5:0] pat;
        pat = 6'b110100;
        eff = (l < sp) ? l : sp;
        sp0 = sp;
        p0 = pops;
        d0 = dones;
        e0 = errs;
        for (int i = 0; i < eff; i++) exp_q.push_back(mem[sp-1-i]);
        start = 1;
        len = LW'(l);
        m_ready = 1;
        step();
        start = 0;
        chk("err_on_start", err, eff == 0);
        chk("busy_on_start", busy, eff != 0);
        n = 0;
        while (busy && n < 100) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : (n < 6 ? pat[n] : 1'b1);
            start = restart && n == 1;
            len = LW'(1);
            step();
            n++;
        end
        if (n >= 100) chk("timeout", 1, 0);
        start = 0;
        m_ready = 1;
        step();
        @(negedge clk);
        chk("done_count", dones - d0, eff != 0);
        chk("err_count", errs - e0, eff == 0);
        chk("pop_count", pops - p0, eff);
        chk("cnt_after", sp, sp0 - eff);
        chk("words_left", exp_q.size(), 0);
    endtask

    initial begin
        int d0, k;
        repeat (3) step();
        chk("rst_m_data", m_data, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req", lifo_r_req, 0);
        nrst = 1;
        step();
        push_word(32'hA0A0_0001);
        push_word(32'hB0B0_0002);
        push_word(32'hC0C0_0003);
        exp_q.push_back(32'hC0C0_0003);
        exp_q.push_back(32'hB0B0_0002);
        start = 1;
        len = LW'(2);
        step();
        start = 0;
        chk("c1_req", lifo_r_req, 1);
        chk("c1_valid", m_valid, 0);
        chk("c1_busy", busy, 1);
        step();
        chk("c2_valid", m_valid, 1);
        chk("c2_data", m_data, 32'hC0C0_0003);
        chk("c2_last", m_last, 0);
        step();
        chk("c3_data", m_data, 32'hB0B0_0002);
        chk("c3_last", m_last, 1);
        step();
        chk("c4_done", done, 1);
        chk("c4_busy", busy, 0);
        chk("c4_cnt", lifo_cnt, 1);
        step();
        clear();
        push_word(32'h1111_0001);
        push_word(32'h2222_0002);
        push_word(32'h3333_0003);
        burst(5, 0, 0);
        clear();
        burst(3, 0, 0);
        push_word(32'h4444_0004);
        burst(0, 0, 0);
        clear();
        push_word(32'h5555_0001);
        push_word(32'h6666_0002);
        push_word(32'h7777_0003);
        burst(3, 2, 0);
        clear();
        for (int i = 0; i < 4; i++) push_word(32'h8000_0000 + i);
        burst(3, 0, 1);
        clear();
        push_word(32'h9999_0001);
        push_word(32'hAAAA_0002);
        push_word(32'hBBBB_0003);
        d0 = dones;
        start = 1;
        len = LW'(3);
        step();
        start = 0;
        step();
        chk("rst_mid_valid_before", m_valid, 1);
        nrst = 0;
        step();
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        nrst = 1;
        exp_q.delete();
        step();
        chk("rst_mid_no_done", dones - d0, 0);
        burst(3, 0, 0);
        repeat (25) begin
            if ($urandom % 3 == 0) clear();
            k = $urandom_range(0, 4);
            for (int i = 0; i < k && sp < DEPTH; i++) push_word($urandom);
            burst($urandom_range(0, 9), $urandom_range(0, 1), 1'($urandom % 2));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
